// File: rtl/can_pkg.sv
// Shared CAN receive/transmit constants: field codes, field lengths, DLC decode.
// Pure declarations; no logic or latency of its own.
package can_pkg;

   typedef enum logic [4:0] {
      F_IDLE    = 5'd0,
      F_ID_A    = 5'd1,
      F_BIT_A   = 5'd2,
      F_IDE     = 5'd3,
      F_ID_B    = 5'd4,
      F_BIT_B   = 5'd5,
      F_FDF     = 5'd6,
      F_R0      = 5'd7,
      F_RES     = 5'd8,
      F_BRS     = 5'd9,
      F_ESI     = 5'd10,
      F_DLC     = 5'd11,
      F_DATA    = 5'd12,
      F_CRC     = 5'd13,
      F_CRC_DEL = 5'd14,
      F_ACK     = 5'd15,
      F_ACK_DEL = 5'd16,
      F_EOF     = 5'd17
   } field_e;

   localparam logic [9:0] ID_A_LEN  = 10'd11;
   localparam logic [9:0] ID_B_LEN  = 10'd18;
   localparam logic [9:0] DLC_LEN   = 10'd4;
   localparam logic [9:0] EOF_LEN   = 10'd7;
   localparam logic [9:0] CRC15_LEN = 10'd15;
   localparam logic [9:0] CRC17_LEN = 10'd17;
   localparam logic [9:0] CRC21_LEN = 10'd21;

   // Classic frames saturate at 8 bytes; FD codes 9..15 step up to 64.
   function automatic logic [6:0] dlc_to_bytes(input logic [3:0] dlc, input logic edl);
      logic [6:0] b;
      if (dlc <= 4'd8)
         b = {3'b000, dlc};
      else if (!edl)
         b = 7'd8;
      else begin
         case (dlc)
            4'd9:    b = 7'd12;
            4'd10:   b = 7'd16;
            4'd11:   b = 7'd20;
            4'd12:   b = 7'd24;
            4'd13:   b = 7'd32;
            4'd14:   b = 7'd48;
            default: b = 7'd64;
         endcase
      end
      return b;
   endfunction

endpackage

// File: rtl/can_len_decode.sv
// Maps DLC/EDL to payload bytes and CRC field length; purely combinational.
// No state, no flow control.
module can_len_decode
   import can_pkg::*;
(
   input  logic [3:0] dlc,
   input  logic       edl,
   output logic [6:0] data_bytes,
   output logic [9:0] crc_len
);

   always_comb begin
      data_bytes = dlc_to_bytes(dlc, edl);
      if (!edl)
         crc_len = CRC15_LEN;
      else if (data_bytes <= 7'd16)
         crc_len = CRC17_LEN;
      else
         crc_len = CRC21_LEN;
   end

endmodule

// File: rtl/can_frame_sequencer.sv
// Walks CAN/CAN FD receive fields one destuffed bit per event; outputs registered, 1 cycle after SP.
// No backpressure: every qualified sample point is consumed, stuff bits are ignored.
module can_frame_sequencer
   import can_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        SP,
   input  logic        RX_BIT,
   input  logic        BIT_VALID,
   output logic [4:0]  FIELD,
   output logic [28:0] ID,
   output logic        IDE,
   output logic        RTR,
   output logic        EDL,
   output logic        BRS,
   output logic        ESI,
   output logic [3:0]  DLC,
   output logic [6:0]  DATA_BYTES,
   output logic        TYPE_FR,
   output logic        FRAME_DONE,
   output logic        FORM_ERR
);

   field_e     state, state_nxt;
   logic [9:0] cnt, cnt_nxt;
   logic       done_nxt, err_nxt;
   logic       bit_a;
   logic [9:0] crc_len_q;
   logic [6:0] dec_bytes;
   logic [9:0] dec_crc_len;
   logic [3:0] dlc_shift;
   logic       ev, last;

   assign ev        = SP & BIT_VALID;
   assign last      = (cnt == 10'd0);
   assign dlc_shift = {DLC[2:0], RX_BIT};

   can_len_decode u_len (
      .dlc        (dlc_shift),
      .edl        (EDL),
      .data_bytes (dec_bytes),
      .crc_len    (dec_crc_len)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= F_IDLE;
         cnt        <= 10'd0;
         FRAME_DONE <= 1'b0;
         FORM_ERR   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         FRAME_DONE <= done_nxt;
         FORM_ERR   <= err_nxt;
      end
   end

   // Single-bit fields need no load: the counter already sits at 0 on exit.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if (ev) begin
         if (!last)
            cnt_nxt = cnt - 10'd1;
         case (state)
            F_IDLE:    if (!RX_BIT) begin state_nxt = F_ID_A; cnt_nxt = ID_A_LEN - 10'd1; end
            F_ID_A:    if (last) state_nxt = F_BIT_A;
            F_BIT_A:   state_nxt = F_IDE;
            F_IDE:     if (RX_BIT) begin state_nxt = F_ID_B; cnt_nxt = ID_B_LEN - 10'd1; end
                       else state_nxt = F_FDF;
            F_ID_B:    if (last) state_nxt = F_BIT_B;
            F_BIT_B:   state_nxt = F_FDF;
            F_FDF: begin
               if (RX_BIT)
                  state_nxt = F_RES;
               else if (IDE)
                  state_nxt = F_R0;
               else begin
                  state_nxt = F_DLC;
                  cnt_nxt   = DLC_LEN - 10'd1;
               end
            end
            F_R0:      begin state_nxt = F_DLC; cnt_nxt = DLC_LEN - 10'd1; end
            F_RES:     state_nxt = F_BRS;
            F_BRS:     state_nxt = F_ESI;
            F_ESI:     begin state_nxt = F_DLC; cnt_nxt = DLC_LEN - 10'd1; end
            F_DLC: begin
               if (last) begin
                  if (RTR || dec_bytes == 7'd0) begin
                     state_nxt = F_CRC;
                     cnt_nxt   = dec_crc_len - 10'd1;
                  end else begin
                     state_nxt = F_DATA;
                     cnt_nxt   = {dec_bytes, 3'b000} - 10'd1;
                  end
               end
            end
            F_DATA:    if (last) begin state_nxt = F_CRC; cnt_nxt = crc_len_q - 10'd1; end
            F_CRC:     if (last) state_nxt = F_CRC_DEL;
            F_CRC_DEL: if (!RX_BIT) begin state_nxt = F_IDLE; err_nxt = 1'b1; end
                       else state_nxt = F_ACK;
            F_ACK:     state_nxt = F_ACK_DEL;
            F_ACK_DEL: if (!RX_BIT) begin state_nxt = F_IDLE; err_nxt = 1'b1; end
                       else begin state_nxt = F_EOF; cnt_nxt = EOF_LEN - 10'd1; end
            F_EOF: begin
               if (!RX_BIT) begin
                  state_nxt = F_IDLE;
                  cnt_nxt   = 10'd0;
                  err_nxt   = 1'b1;
               end else if (last) begin
                  state_nxt = F_IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default: begin state_nxt = F_IDLE; cnt_nxt = 10'd0; end
         endcase
      end
   end

   always_comb begin
      FIELD   = state;
      TYPE_FR = RTR & ~EDL;
   end

   // RTR is committed at IDE (base) or BIT_B (extended) so SRR never shows on the port.
   always_ff @(posedge clock) begin
      if (reset) begin
         ID         <= '0;
         IDE        <= 1'b0;
         RTR        <= 1'b0;
         EDL        <= 1'b0;
         BRS        <= 1'b0;
         ESI        <= 1'b0;
         DLC        <= '0;
         DATA_BYTES <= '0;
         bit_a      <= 1'b0;
         crc_len_q  <= '0;
      end else if (ev) begin
         case (state)
            F_IDLE: begin
               if (!RX_BIT) begin
                  ID         <= '0;
                  IDE        <= 1'b0;
                  RTR        <= 1'b0;
                  EDL        <= 1'b0;
                  BRS        <= 1'b0;
                  ESI        <= 1'b0;
                  DLC        <= '0;
                  DATA_BYTES <= '0;
                  bit_a      <= 1'b0;
                  crc_len_q  <= '0;
               end
            end
            F_ID_A:  ID[28:18] <= {ID[27:18], RX_BIT};
            F_BIT_A: bit_a <= RX_BIT;
            F_IDE: begin
               IDE <= RX_BIT;
               if (!RX_BIT)
                  RTR <= bit_a;
            end
            F_ID_B:  ID[17:0] <= {ID[16:0], RX_BIT};
            F_BIT_B: RTR <= RX_BIT;
            F_FDF: begin
               EDL <= RX_BIT;
               if (RX_BIT)
                  RTR <= 1'b0;
            end
            F_BRS:   BRS <= RX_BIT;
            F_ESI:   ESI <= RX_BIT;
            F_DLC: begin
               DLC <= dlc_shift;
               if (last) begin
                  DATA_BYTES <= dec_bytes;
                  crc_len_q  <= dec_crc_len;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/can_frame_sequencer.md
# can_frame_sequencer

Bit-level frame sequencer for the CAN/CAN FD receive path. It consumes one destuffed bit per sample point and walks a field state machine from SOF to EOF. It captures ID, IDE, RTR, EDL, BRS, ESI and DLC, and derives the frame type and payload length. It tells the downstream field blocks (type-of-frame, CRC, data capture) which field the current bit belongs to, and flags form errors on fixed-format bits.

## Interface
Parameters:
- none; all constants live in `can_pkg`.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `SP`  in  1  sample-point strobe, one `clock` cycle wide.
- `RX_BIT`  in  1  sampled bus value; 0 is dominant.
- `BIT_VALID`  in  1  qualifies `RX_BIT` at `SP`; 0 marks a stuff bit, which the sequencer ignores.
- `FIELD`  out  5  current field code (`can_pkg::field_e`).
- `ID`  out  29  identifier; base ID in [28:18], extension in [17:0].
- `IDE`, `RTR`, `EDL`, `BRS`, `ESI`  out  1 each  captured control bits.
- `DLC`  out  4  captured DLC.
- `DATA_BYTES`  out  7  payload length in bytes (0..64).
- `TYPE_FR`  out  1  0 = data frame, 1 = remote frame; valid from exit of DLC.
- `FRAME_DONE`  out  1  one-cycle pulse, frame completed.
- `FORM_ERR`  out  1  one-cycle pulse, fixed-format violation.

## Operation
- An event is a cycle with `SP=1` and `BIT_VALID=1`. Only events advance state, counters or captures.
- States, with bits consumed per state:
  - IDLE
  - ID_A (11)
  - BIT_A (1; RTR, or SRR for extended frames)
  - IDE (1)
  - ID_B (18)
  - BIT_B (1; RTR)
  - FDF (1; FDF, r0 or r1)
  - R0 (1)
  - RES (1)
  - BRS (1)
  - ESI (1)
  - DLC (4)
  - DATA (8 × DATA_BYTES)
  - CRC (15/17/21)
  - CRC_DEL (1)
  - ACK (1)
  - ACK_DEL (1)
  - EOF (7)
- IDLE: `RX_BIT=0` is SOF. On SOF, clear all captures and go to ID_A. `RX_BIT=1` keeps IDLE.
- Transitions:
  - ID_A → BIT_A → IDE.
  - IDE=0 → FDF; IDE=1 → ID_B → BIT_B → FDF.
  - FDF=0: base frames go to DLC; extended frames go to R0 then DLC.
  - FDF=1 → RES → BRS → ESI → DLC.
- `RTR` takes the value from BIT_A when IDE=0, otherwise from BIT_B. `RTR` is forced to 0 when EDL=1.
- `TYPE_FR` = `RTR & ~EDL`.
- `DATA_BYTES` mapping:
  - EDL=0: min(DLC, 8).
  - EDL=1: DLC 0..8 map directly; 9..15 map to 12, 16, 20, 24, 32, 48, 64.
- Leaving DLC: if RTR=1 or DATA_BYTES=0, skip DATA and go to CRC.
- CRC length: 15 if EDL=0; 17 if EDL=1 and DATA_BYTES ≤ 16; 21 otherwise.
- `ID` and `DLC` shift in MSB-first, one bit per event.
- Bit counter: 10 bits, loaded on field entry with (field length − 1). It decrements per event, and the field exits on the event seen at count 0.
- CRC_DEL, ACK_DEL and every EOF bit must be 1. A 0 pulses `FORM_ERR`, returns to IDLE and does not produce `FRAME_DONE`. The ACK slot value is don't-care.
- The 7th EOF bit pulses `FRAME_DONE` and returns to IDLE. Captured fields hold until the next SOF.

## Timing
- Reset values: state IDLE, `FIELD`=IDLE, all captures 0, `DATA_BYTES`=0, both pulses 0.
- All outputs are registered and update on the `clock` edge that samples the event, so they are visible 1 cycle after the `SP` cycle.
- `FIELD` shows the field the next bit belongs to.
- `FRAME_DONE` and `FORM_ERR` are high for exactly 1 cycle and never coincide.
- `SP=1` with `BIT_VALID=0`: no state or capture change.
- `reset` and `SP` in the same cycle: reset wins and the bit is dropped.
- Reset mid-frame: IDLE on the next edge; a partial frame produces no pulse.
- An `SP` in the cycle after a `FORM_ERR` is evaluated in IDLE; a 0 starts a new frame.

## Structure
- `can_pkg` holds:
  - `field_e` enum (5-bit codes).
  - Field-length constants: ID_A_LEN=11, ID_B_LEN=18, EOF_LEN=7, CRC15/17/21.
  - `dlc_to_bytes(dlc, edl)` function.
- One combinational sub-module, `can_len_decode`: maps DLC and EDL to DATA_BYTES and CRC length. It is reused by the transmit path.
- The main FSM is a single-process next-state block, with a counter and capture registers in `can_frame_sequencer`.

## Test plan
- Base data frame: ID 0x123, RTR=0, IDE=0, r0=0, DLC=2, data 0xAB 0xCD, valid delimiters and EOF → ID[28:18]=0x123, DATA_BYTES=2, TYPE_FR=0, `FRAME_DONE` pulse 1 cycle after the 7th EOF `SP`.
- Extended remote frame: ID 0x1ABCDE01, RTR=1, DLC=4 → TYPE_FR=1, DATA skipped (FIELD goes DLC→CRC), 15 CRC bits, `FRAME_DONE`.
- FD frame: base ID 0x7FF, FDF=1, BRS=1, ESI=0, DLC=0xF → DATA_BYTES=64, 512 data events, CRC length 21, RTR=0, EDL=1.
- Stuff bits: `BIT_VALID=0` interleaved after every 5 bits of the first scenario → identical captures and timing relative to valid events.
- Form error: ACK_DEL=0 → `FORM_ERR` pulse, FIELD=IDLE, no `FRAME_DONE`; the next dominant `SP` starts a new frame.
- Reset in DATA after 3 bytes → IDLE and all outputs 0 next cycle; a following complete frame decodes correctly.
